// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : IF/LSU arbiter for a single-port synchronous data memory, with
//            LSU lock and read-response steering. Optional IF starvation guard
//            is enabled with the ARB_STARVE_GUARD_EN macro.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_if_req,
   input  logic [ADDR_W-1:0]   i_if_addr,
   output logic                o_if_gnt,
   output logic                o_if_rvld,
   output logic [DATA_W-1:0]   o_if_rdata,
   input  logic                i_lsu_req,
   input  logic                i_lsu_we,
   input  logic                i_lsu_lock,
   input  logic [ADDR_W-1:0]   i_lsu_addr,
   input  logic [DATA_W-1:0]   i_lsu_wdata,
   input  logic [DATA_W/8-1:0] i_lsu_bmask,
   output logic                o_lsu_gnt,
   output logic                o_lsu_rvld,
   output logic [DATA_W-1:0]   o_lsu_rdata,
   output logic                o_mem_en,
   output logic                o_mem_we,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_wdata,
   output logic [DATA_W/8-1:0] o_mem_bmask,
   input  logic [DATA_W-1:0]   i_mem_rdata,
   output logic                o_locked
);

   typedef enum logic [0:0] {
      OPEN   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   w_if_gnt;
   logic   w_lsu_gnt;
   logic   w_force_if;
   logic   r_rd_pending;
   logic   r_rd_lsu;

   generate
      if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
         $error("mem_port_arbiter: MAX_WAIT must be within 1..15");
      end
   endgenerate

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);
   logic [3:0] r_wait_cnt;

   assign w_force_if = (r_wait_cnt == C_MAX_WAIT);

   // Counts IF cycles lost to LSU while open; frozen while the LSU holds a lock.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wait_cnt <= '0;
      end else if (!i_if_req || w_if_gnt) begin
         r_wait_cnt <= '0;
      end else if (r_state == OPEN && r_wait_cnt != 4'hF) begin
         r_wait_cnt <= r_wait_cnt + 4'd1;
      end
   end
`else
   assign w_force_if = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= OPEN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_if_gnt    = 1'b0;
      w_lsu_gnt   = 1'b0;
      w_state_nxt = r_state;
      if (!i_reset) begin
         case (r_state)
            OPEN: begin
               if (i_lsu_req && !(i_if_req && w_force_if)) begin
                  w_lsu_gnt = 1'b1;
               end else if (i_if_req) begin
                  w_if_gnt = 1'b1;
               end
               if (w_lsu_gnt && i_lsu_lock) begin
                  w_state_nxt = LOCKED;
               end
            end
            LOCKED: begin
               w_lsu_gnt = i_lsu_req;
               if ((w_lsu_gnt && !i_lsu_lock) || (!i_lsu_req && !i_lsu_lock)) begin
                  w_state_nxt = OPEN;
               end
            end
            default: w_state_nxt = OPEN;
         endcase
      end
   end

   always_comb begin
      o_mem_en    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_bmask = '0;
      if (w_lsu_gnt) begin
         o_mem_en    = 1'b1;
         o_mem_we    = i_lsu_we;
         o_mem_addr  = i_lsu_addr;
         o_mem_wdata = i_lsu_wdata;
         o_mem_bmask = i_lsu_bmask;
      end else if (w_if_gnt) begin
         o_mem_en    = 1'b1;
         o_mem_addr  = i_if_addr;
         o_mem_bmask = '1;
      end
   end

   // Read tracker: remembers who owns the data returning next cycle.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rd_pending <= 1'b0;
         r_rd_lsu     <= 1'b0;
      end else begin
         r_rd_pending <= w_if_gnt | (w_lsu_gnt & ~i_lsu_we);
         r_rd_lsu     <= w_lsu_gnt;
      end
   end

   assign o_if_gnt    = w_if_gnt;
   assign o_lsu_gnt   = w_lsu_gnt;
   assign o_if_rvld   = r_rd_pending & ~r_rd_lsu & ~i_reset;
   assign o_lsu_rvld  = r_rd_pending & r_rd_lsu & ~i_reset;
   assign o_if_rdata  = o_if_rvld  ? i_mem_rdata : '0;
   assign o_lsu_rdata = o_lsu_rvld ? i_mem_rdata : '0;
   assign o_locked    = (r_state == LOCKED) & ~i_reset;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter with a read
//            response scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvld;
   logic [31:0] if_rdata;
   logic        lsu_req, lsu_we, lsu_lock;
   logic [31:0] lsu_addr, lsu_wdata;
   logic [3:0]  lsu_bmask;
   logic        lsu_gnt, lsu_rvld;
   logic [31:0] lsu_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_bmask;
   logic [31:0] mem_rdata;
   logic        locked;

   typedef struct packed {
      logic        lsu;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];
   int   n_err    = 0;
   int   n_checks = 0;

   mem_port_arbiter dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_if_req   (if_req),
      .i_if_addr  (if_addr),
      .o_if_gnt   (if_gnt),
      .o_if_rvld  (if_rvld),
      .o_if_rdata (if_rdata),
      .i_lsu_req  (lsu_req),
      .i_lsu_we   (lsu_we),
      .i_lsu_lock (lsu_lock),
      .i_lsu_addr (lsu_addr),
      .i_lsu_wdata(lsu_wdata),
      .i_lsu_bmask(lsu_bmask),
      .o_lsu_gnt  (lsu_gnt),
      .o_lsu_rvld (lsu_rvld),
      .o_lsu_rdata(lsu_rdata),
      .o_mem_en   (mem_en),
      .o_mem_we   (mem_we),
      .o_mem_addr (mem_addr),
      .o_mem_wdata(mem_wdata),
      .o_mem_bmask(mem_bmask),
      .i_mem_rdata(mem_rdata),
      .o_locked   (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [31:0] a);
      if (a == 32'h40) return 32'hDEADBEEF;
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   // Memory: registered read of the model; junk on non-read cycles.
   always @(posedge clk) begin
      if (mem_en && !mem_we) mem_rdata <= model(mem_addr);
      else                   mem_rdata <= $urandom;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic resp_check();
      exp_t e;
      if (reset) begin
         check("rst_if_rvld", {31'b0, if_rvld}, 32'd0);
         check("rst_lsu_rvld", {31'b0, lsu_rvld}, 32'd0);
         check("rst_if_rdata", if_rdata, 32'd0);
         check("rst_lsu_rdata", lsu_rdata, 32'd0);
         q.delete();
      end else if (q.size() > 0) begin
         e = q.pop_front();
         check("if_rvld", {31'b0, if_rvld}, {31'b0, ~e.lsu});
         check("lsu_rvld", {31'b0, lsu_rvld}, {31'b0, e.lsu});
         check("if_rdata", if_rdata, e.lsu ? 32'd0 : e.data);
         check("lsu_rdata", lsu_rdata, e.lsu ? e.data : 32'd0);
      end else begin
         check("idle_if_rvld", {31'b0, if_rvld}, 32'd0);
         check("idle_lsu_rvld", {31'b0, lsu_rvld}, 32'd0);
      end
   endtask

   // One cycle: inputs already driven; check responses, grants, mem port, lock.
   task automatic step(input logic eif, input logic elsu, input logic elk);
      #1;
      resp_check();
      check("if_gnt", {31'b0, if_gnt}, {31'b0, eif});
      check("lsu_gnt", {31'b0, lsu_gnt}, {31'b0, elsu});
      check("locked", {31'b0, locked}, {31'b0, elk});
      if (elsu) begin
         check("mem_en", {31'b0, mem_en}, 32'd1);
         check("mem_we", {31'b0, mem_we}, {31'b0, lsu_we});
         check("mem_addr", mem_addr, lsu_addr);
         check("mem_wdata", mem_wdata, lsu_wdata);
         check("mem_bmask", {28'b0, mem_bmask}, {28'b0, lsu_bmask});
         if (!lsu_we) q.push_back('{lsu: 1'b1, data: model(lsu_addr)});
      end else if (eif) begin
         check("mem_en", {31'b0, mem_en}, 32'd1);
         check("mem_we", {31'b0, mem_we}, 32'd0);
         check("mem_addr", mem_addr, if_addr);
         check("mem_wdata", mem_wdata, 32'd0);
         check("mem_bmask", {28'b0, mem_bmask}, 32'hF);
         q.push_back('{lsu: 1'b0, data: model(if_addr)});
      end else begin
         check("mem_en", {31'b0, mem_en}, 32'd0);
         check("mem_we", {31'b0, mem_we}, 32'd0);
         check("mem_addr", mem_addr, 32'd0);
         check("mem_wdata", mem_wdata, 32'd0);
         check("mem_bmask", {28'b0, mem_bmask}, 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic f;
      mem_rdata = '0;
      reset = 1'b1; if_req = 1'b0; if_addr = '0;
      lsu_req = 1'b0; lsu_we = 1'b0; lsu_lock = 1'b0;
      lsu_addr = '0; lsu_wdata = '0; lsu_bmask = '0;
      step(0, 0, 0);
      // Requests during reset are ignored
      if_req = 1; lsu_req = 1; lsu_addr = 32'h10;
      step(0, 0, 0);
      reset = 0; if_req = 0; lsu_req = 0;
      step(0, 0, 0);

      // IF read only
      if_req = 1; if_addr = 32'h40;
      step(1, 0, 0);
      if_req = 0;
      step(0, 0, 0);

      // Contention: LSU first, then IF, responses in grant order
      if_req = 1; if_addr = 32'h44;
      lsu_req = 1; lsu_we = 0; lsu_addr = 32'h100;
      step(0, 1, 0);
      lsu_req = 0;
      step(1, 0, 0);
      if_req = 0;
      step(0, 0, 0);

      // Back-to-back LSU reads
      lsu_req = 1; lsu_addr = 32'h200;
      step(0, 1, 0);
      lsu_addr = 32'h204;
      step(0, 1, 0);
      lsu_req = 0;
      step(0, 0, 0);

      // LSU partial write
      lsu_req = 1; lsu_we = 1; lsu_addr = 32'h300; lsu_wdata = 32'h12345678; lsu_bmask = 4'b0011;
      step(0, 1, 0);
      lsu_req = 0; lsu_we = 0; lsu_bmask = 4'hF; lsu_wdata = 0;
      step(0, 0, 0);

      // Locked read-modify-write with IF waiting throughout
      if_req = 1; if_addr = 32'h48;
      lsu_req = 1; lsu_lock = 1; lsu_addr = 32'h400;
      step(0, 1, 0);
      lsu_req = 0;
      for (int i = 0; i < 3; i++) step(0, 0, 1);
      lsu_req = 1; lsu_we = 1; lsu_lock = 0; lsu_wdata = 32'hCAFE0001;
      step(0, 1, 1);
      lsu_req = 0; lsu_we = 0;
      step(1, 0, 0);
      if_req = 0;
      step(0, 0, 0);

      // Lock released by an idle cycle while IF starts requesting
      lsu_req = 1; lsu_lock = 1; lsu_addr = 32'h500;
      step(0, 1, 0);
      lsu_req = 0; lsu_lock = 0; if_req = 1; if_addr = 32'h4C;
      step(0, 0, 1);
      step(1, 0, 0);
      if_req = 0;
      step(0, 0, 0);

      // Continuous contention: starvation guard pattern (or strict priority)
      if_req = 1; if_addr = 32'h50; lsu_req = 1; lsu_addr = 32'h600;
      for (int i = 0; i < 10; i++) begin
         f = GUARD && (i % 5 == 4);
         step(f, !f, 0);
         if (!f) lsu_addr = lsu_addr + 32'd4;
      end
      if_req = 0; lsu_req = 0;
      step(0, 0, 0);

      // Reset right after a granted read discards the response
      if_req = 1; if_addr = 32'h54;
      step(1, 0, 0);
      if_req = 0; reset = 1;
      step(0, 0, 0);
      reset = 0; lsu_req = 1; lsu_addr = 32'h700;
      step(0, 1, 0);
      lsu_req = 0;
      step(0, 0, 0);

      // Reset while locked returns the FSM to OPEN
      lsu_req = 1; lsu_lock = 1; lsu_addr = 32'h800;
      step(0, 1, 0);
      lsu_req = 0; reset = 1;
      step(0, 0, 0);
      reset = 0; if_req = 1; if_addr = 32'h58;
      step(1, 0, 0);
      if_req = 0; lsu_lock = 0;
      step(0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port synchronous data memory between the instruction-fetch stage (IF) and the load/store unit (LSU) of the pipelined core. The block grants one requester per cycle and drives the memory port from the winner. It steers the one-cycle-late read data back to the requester that issued the read. LSU normally has priority; an optional starvation guard bounds IF wait time, and an LSU lock supports atomic read-modify-write sequences.

## Interface

Parameters:
- ADDR_W, 32, memory byte-address width
- DATA_W, 32, data width (DATA_W/8 byte lanes)
- MAX_WAIT, 4, consecutive denied IF cycles before IF is forced to win (only with the guard compiled in; legal range 1..15)

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous reset, active-high
- i_if_req  in  1  IF read request, held until granted
- i_if_addr  in  ADDR_W  IF read address
- o_if_gnt  out  1  IF granted this cycle
- o_if_rvld  out  1  IF read data valid
- o_if_rdata  out  DATA_W  IF read data
- i_lsu_req  in  1  LSU request, held until granted
- i_lsu_we  in  1  1 = write, 0 = read
- i_lsu_lock  in  1  keep ownership after this access
- i_lsu_addr  in  ADDR_W  LSU address
- i_lsu_wdata  in  DATA_W  LSU write data
- i_lsu_bmask  in  DATA_W/8  LSU byte enables
- o_lsu_gnt  out  1  LSU granted this cycle
- o_lsu_rvld  out  1  LSU read data valid
- o_lsu_rdata  out  DATA_W  LSU read data
- o_mem_en  out  1  memory access this cycle
- o_mem_we  out  1  memory write
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- o_mem_bmask  out  DATA_W/8  memory byte enables (all ones for IF)
- i_mem_rdata  in  DATA_W  read data, valid the cycle after a read access
- o_locked  out  1  arbiter is in LOCKED state

## Operation

- FSM states: OPEN, LOCKED.
- OPEN: if both requesters are active, LSU wins unless the starvation guard forces IF. A lone requester always wins. LSU grant with i_lsu_lock=1 moves the FSM to LOCKED.
- LOCKED: only LSU is granted, and IF is held off. The FSM returns to OPEN on an LSU grant with i_lsu_lock=0, or on any cycle with i_lsu_req=0 and i_lsu_lock=0.
- Grants are one-hot or zero. o_mem_* is a combinational mux of the granted requester. With no grant, o_mem_en=0 and the other o_mem_* outputs are 0.
- The read tracker registers owner and pending flag on every granted read. Next cycle, the owner's rvld=1 and its rdata=i_mem_rdata. The non-owner's rdata=0. Granted writes produce no rvld.
- Back-to-back reads are pipelined: one grant per cycle, one response per cycle, in order.

## Timing

- Grant is combinational from requests and state in the same cycle, with zero added latency.
- Read latency is 1 cycle from grant to rvld.
- Handshake: the request is held with stable address/data until gnt is seen high. A request deasserted before grant is legal and is dropped.
- Reset value of every output is 0, and the FSM is OPEN. During a reset cycle no grant is issued and o_mem_en=0.
- Reset mid-read: a read granted in the cycle before reset gives no rvld in the reset cycle, and its response is discarded.
- Simultaneous lock release and IF request: IF can be granted no earlier than the cycle after the FSM returns to OPEN.

## Configuration

- ARB_STARVE_GUARD_EN defined: a 4-bit wait counter increments on each cycle where IF requests but is not granted in OPEN. It clears on IF grant or when i_if_req=0. When the count equals MAX_WAIT, IF wins the next OPEN contention. The counter holds (no increment) while LOCKED.
- Not defined: strict LSU priority, no counter logic; IF can starve indefinitely.

## Test plan

- IF read only: i_if_req=1, addr=0x40, mem returns 0xDEADBEEF → o_if_gnt=1 in cycle 0; in cycle 1 o_if_rvld=1 and o_if_rdata=0xDEADBEEF; o_lsu_rvld=0.
- Contention: both request the same cycle, LSU read addr 0x100 → o_lsu_gnt=1 and o_if_gnt=0. IF is granted the next cycle after the LSU drops its request. Responses arrive in grant order.
- LSU write, bmask=4'b0011, wdata=0x12345678 → o_mem_we=1, o_mem_bmask=0011; no rvld on either side the following cycle.
- Lock: LSU read with lock=1, then 3 idle cycles with lock=1, then write with lock=0, while IF requests throughout → o_locked=1 for those cycles and o_if_gnt=0 throughout. o_locked=0 after the write; IF is granted the next cycle.
- Starvation (guard on, MAX_WAIT=4): continuous LSU and IF requests → the LSU is granted 4 times, then IF once, repeating. With the guard off, IF is never granted.
- Reset asserted the cycle after a granted read → no rvld, all outputs 0, FSM OPEN, and the first post-reset request is granted normally.
